// File: rtl/int_to_raw_pkg.sv
// Shared types and width helpers for the pipelined integer-to-raw-float converter.
// Structs are sized for the widest legal operand; narrower instances use the low bits.
package int_to_raw_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if (int'(32'd1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  function automatic int exp_width(input int int_width);
    return clog2(int_width) + 1;
  endfunction

  localparam int MAX_INT_WIDTH = 128;
  localparam int MAX_EXP_WIDTH = exp_width(MAX_INT_WIDTH);

  typedef struct packed {
    logic                     sign;
    logic [MAX_INT_WIDTH-1:0] mag;
    logic [MAX_EXP_WIDTH-1:0] lzc;
  } raw_fn_s1_t;

  typedef struct packed {
    logic                     sign;
    logic                     is_zero;
    logic [MAX_EXP_WIDTH-1:0] sexp;
    logic [MAX_INT_WIDTH-1:0] sig;
  } raw_fn_t;

  localparam raw_fn_s1_t RAW_FN_S1_ZERO = '{
    sign: 1'b0, mag: {MAX_INT_WIDTH{1'b0}}, lzc: {MAX_EXP_WIDTH{1'b0}}
  };
  localparam raw_fn_t RAW_FN_ZERO = '{
    sign: 1'b0, is_zero: 1'b0, sexp: {MAX_EXP_WIDTH{1'b0}}, sig: {MAX_INT_WIDTH{1'b0}}
  };

endpackage

// File: rtl/int_to_raw_fn_pipe_lzc.sv
// Combinational binary-tree leading-zero counter; an all-zero vector yields WIDTH.
// Pads to a power of two with ones below the LSB so padding never adds zeros.
module lead_zero_count
  import int_to_raw_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0]     vec,
  output logic [clog2(WIDTH):0] count
);

  localparam int LEVELS = clog2(WIDTH);
  localparam int PAD    = 1 << LEVELS;
  localparam int CW     = LEVELS + 1;

  logic [PAD-1:0] pad_s;
  logic [CW-1:0]  node_s [LEVELS+1][PAD];
  logic [CW-1:0]  left_s;

  // Tree reduction: node n at level l covers 2^l bits, MSB side first
  always_comb begin
    pad_s = {PAD{1'b1}};
    pad_s[PAD-1 -: WIDTH] = vec;
    left_s = {CW{1'b0}};
    for (int l = 0; l <= LEVELS; l++) begin
      for (int n = 0; n < PAD; n++) begin
        node_s[l][n] = {CW{1'b0}};
      end
    end
    for (int n = 0; n < PAD; n++) begin
      node_s[0][n] = {{(CW-1){1'b0}}, ~pad_s[PAD-1-n]};
    end
    for (int l = 1; l <= LEVELS; l++) begin
      for (int n = 0; n < (PAD >> l); n++) begin
        left_s = node_s[l-1][2*n];
        // A left half that is all zeros carries its count into the right half
        if (left_s[l-1]) begin
          node_s[l][n] = left_s + node_s[l-1][2*n+1];
        end else begin
          node_s[l][n] = left_s;
        end
      end
    end
    count = node_s[LEVELS][0];
  end

endmodule

// File: rtl/int_to_raw_fn_pipe.sv
// Two-stage integer-to-raw-float converter with valid/ready and bubble collapsing.
// Optional INT_TO_RAW_STATS_EN adds saturating consumed-result and zero-result counters.
module int_to_raw_fn_pipe
  import int_to_raw_pkg::*;
#(
  parameter int INT_WIDTH = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_signed,
  input  logic [INT_WIDTH-1:0]          in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_sign,
  output logic                          out_is_zero,
  output logic [exp_width(INT_WIDTH)-1:0] out_sexp,
  output logic [INT_WIDTH-1:0]          out_sig
`ifdef INT_TO_RAW_STATS_EN
  ,
  output logic [31:0]                   stat_conv,
  output logic [31:0]                   stat_zero
`endif
);

  localparam int EXP_WIDTH = exp_width(INT_WIDTH);

  logic                 s1_valid_r;
  logic                 s2_valid_r;
  raw_fn_s1_t           s1_r;
  raw_fn_t              s2_r;
  raw_fn_s1_t           s1_d_s;
  raw_fn_t              s2_d_s;
  logic                 s1_load_s;
  logic                 s2_load_s;
  logic                 sign_s;
  logic [INT_WIDTH-1:0] mag_s;
  logic [EXP_WIDTH-1:0] lzc_s;
  logic [INT_WIDTH-1:0] mag2_s;
  logic [EXP_WIDTH-1:0] lzc2_s;
  logic [INT_WIDTH-1:0] sig2_s;
  logic [EXP_WIDTH-1:0] sexp2_s;
  logic                 unused_bits_s;

  assign s2_load_s = s1_valid_r && (!s2_valid_r || out_ready);
  assign s1_load_s = !s1_valid_r || s2_load_s;
  // out_ready reaches in_ready combinationally so a full pipe still streams at full rate
  assign in_ready  = s1_load_s && !reset;

  lead_zero_count #(.WIDTH(INT_WIDTH)) u_lzc (
    .vec   (mag_s),
    .count (lzc_s)
  );

  // Stage 1 datapath: sign extraction and magnitude
  always_comb begin
    sign_s = in_signed & in_data[INT_WIDTH-1];
    if (sign_s) begin
      mag_s = {INT_WIDTH{1'b0}} - in_data;
    end else begin
      mag_s = in_data;
    end
    s1_d_s      = RAW_FN_S1_ZERO;
    s1_d_s.sign = sign_s;
    s1_d_s.mag  = MAX_INT_WIDTH'(mag_s);
    s1_d_s.lzc  = MAX_EXP_WIDTH'(lzc_s);
  end

  // Stage 2 datapath: normalise and form the exponent; zero operands clear every field
  always_comb begin
    mag2_s  = s1_r.mag[INT_WIDTH-1:0];
    lzc2_s  = s1_r.lzc[EXP_WIDTH-1:0];
    sig2_s  = mag2_s << lzc2_s;
    sexp2_s = EXP_WIDTH'(INT_WIDTH - 1) - lzc2_s;
    s2_d_s  = RAW_FN_ZERO;
    if (mag2_s == {INT_WIDTH{1'b0}}) begin
      s2_d_s.is_zero = 1'b1;
    end else begin
      s2_d_s.sign = s1_r.sign;
      s2_d_s.sexp = MAX_EXP_WIDTH'(sexp2_s);
      s2_d_s.sig  = MAX_INT_WIDTH'(sig2_s);
    end
  end

  // Stage 1 register: payload moves only on an accepted beat
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_r       <= RAW_FN_S1_ZERO;
    end else if (s1_load_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_r <= s1_d_s;
      end
    end
  end

  // Stage 2 register: fills from S1 when empty or being drained, else empties on consume
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid_r <= 1'b0;
      s2_r       <= RAW_FN_ZERO;
    end else if (s2_load_s) begin
      s2_valid_r <= 1'b1;
      s2_r       <= s2_d_s;
    end else if (out_ready) begin
      s2_valid_r <= 1'b0;
    end
  end

  assign out_valid   = s2_valid_r;
  assign out_sign    = s2_r.sign;
  assign out_is_zero = s2_r.is_zero;
  assign out_sexp    = s2_r.sexp[EXP_WIDTH-1:0];
  assign out_sig     = s2_r.sig[INT_WIDTH-1:0];

  // Upper struct bits beyond INT_WIDTH are constant zero by construction
  assign unused_bits_s = ^{s1_r, s2_r};

`ifdef INT_TO_RAW_STATS_EN
  logic consume_s;
  assign consume_s = s2_valid_r && out_ready;

  // Saturating result counters, updated together when both apply
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_conv <= 32'd0;
      stat_zero <= 32'd0;
    end else if (consume_s) begin
      if (stat_conv != 32'hFFFF_FFFF) begin
        stat_conv <= stat_conv + 32'd1;
      end
      if (s2_r.is_zero && (stat_zero != 32'hFFFF_FFFF)) begin
        stat_zero <= stat_zero + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_int_to_raw_fn_pipe.sv
// Directed and table-driven bench for int_to_raw_fn_pipe at INT_WIDTH = 8.
module tb_int_to_raw_fn_pipe;

  typedef struct packed {
    logic       sign;
    logic       is_zero;
    logic [3:0] sexp;
    logic [7:0] sig;
  } res_t;

  typedef struct packed {
    logic       sgn;
    logic [7:0] data;
    res_t       exp;
  } vec_t;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       in_signed;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sign;
  logic       out_is_zero;
  logic [3:0] out_sexp;
  logic [7:0] out_sig;
`ifdef INT_TO_RAW_STATS_EN
  logic [31:0] stat_conv;
  logic [31:0] stat_zero;
`endif

  int checks;
  int failures;

  int_to_raw_fn_pipe #(.INT_WIDTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_signed   (in_signed),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sign    (out_sign),
    .out_is_zero (out_is_zero),
    .out_sexp    (out_sexp),
    .out_sig     (out_sig)
`ifdef INT_TO_RAW_STATS_EN
    ,
    .stat_conv   (stat_conv),
    .stat_zero   (stat_zero)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic res_t dut_res();
    return {out_sign, out_is_zero, out_sexp, out_sig};
  endfunction

  // Reference: find the highest set bit by scanning, then shift it to bit 7
  function automatic res_t ref_model(input logic sgn, input logic [7:0] d);
    res_t r;
    logic [7:0] m;
    r = {1'b0, 1'b0, 4'd0, 8'd0};
    r.sign = sgn & d[7];
    m = r.sign ? (8'd0 - d) : d;
    if (m == 8'd0) begin
      r.sign = 1'b0;
      r.is_zero = 1'b1;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (m[i]) begin
          r.sexp = i[3:0];
          r.sig  = m << (7 - i);
        end
      end
    end
    return r;
  endfunction

  vec_t vecs [12];
  res_t q [$];
  int   got;
  int   sent;
  int   stale;
  logic drop;

  initial begin
    checks = 0;
    failures = 0;
    vecs[0]  = '{1'b0, 8'h01, '{1'b0, 1'b0, 4'd0, 8'h80}};
    vecs[1]  = '{1'b1, 8'h80, '{1'b1, 1'b0, 4'd7, 8'h80}};
    vecs[2]  = '{1'b0, 8'h80, '{1'b0, 1'b0, 4'd7, 8'h80}};
    vecs[3]  = '{1'b1, 8'hFF, '{1'b1, 1'b0, 4'd0, 8'h80}};
    vecs[4]  = '{1'b0, 8'h00, '{1'b0, 1'b1, 4'd0, 8'h00}};
    vecs[5]  = '{1'b1, 8'h00, '{1'b0, 1'b1, 4'd0, 8'h00}};
    vecs[6]  = '{1'b0, 8'hFF, '{1'b0, 1'b0, 4'd7, 8'hFF}};
    vecs[7]  = '{1'b1, 8'h7F, '{1'b0, 1'b0, 4'd6, 8'hFE}};
    vecs[8]  = '{1'b1, 8'hFA, '{1'b1, 1'b0, 4'd2, 8'hC0}};
    vecs[9]  = '{1'b0, 8'h05, '{1'b0, 1'b0, 4'd2, 8'hA0}};
    vecs[10] = '{1'b0, 8'h12, '{1'b0, 1'b0, 4'd4, 8'h90}};
    vecs[11] = '{1'b1, 8'h81, '{1'b1, 1'b0, 4'd6, 8'hFE}};

    reset = 1'b1; in_valid = 1'b0; in_signed = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_outputs", dut_res(), 14'd0);
    check("reset_in_ready", in_ready, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("post_reset_in_ready", in_ready, 1'b1);

    // Table vectors, one beat at a time, with latency check
    foreach (vecs[i]) begin
      @(negedge clock);
      out_ready = 1'b1; in_signed = vecs[i].sgn; in_data = vecs[i].data; in_valid = 1'b1;
      #1;
      check("vec_in_ready", in_ready, 1'b1);
      @(negedge clock);
      in_valid = 1'b0;
      #1;
      check("vec_not_early", out_valid, 1'b0);
      @(negedge clock);
      #1;
      check("vec_valid", out_valid, 1'b1);
      check($sformatf("vec%0d_result", i), dut_res(), vecs[i].exp);
    end

    // Stall: three back-to-back beats against a blocked output
    @(negedge clock);
    out_ready = 1'b0; in_signed = 1'b0; in_valid = 1'b1; in_data = 8'h03;
    @(negedge clock);
    #1;
    check("stall_ready_1", in_ready, 1'b1);
    in_data = 8'h05;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      in_data = 8'h07;
      #1;
      check("stall_in_ready_low", in_ready, 1'b0);
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_hold", dut_res(), ref_model(1'b0, 8'h03));
    end
    q.push_back(ref_model(1'b0, 8'h03));
    q.push_back(ref_model(1'b0, 8'h05));
    q.push_back(ref_model(1'b0, 8'h07));
    got = 0;
    drop = 1'b0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      @(negedge clock);
      out_ready = 1'b1;
      if (drop) in_valid = 1'b0;
      #1;
      if (out_valid) begin
        check("stall_order", dut_res(), q.pop_front());
        got++;
      end
      if (in_valid && in_ready) drop = 1'b1;
    end
    check("stall_all_out", got, 3);
    in_valid = 1'b0;
    @(negedge clock);
    #1;
    check("stall_no_dup", out_valid, 1'b0);
    q.delete();

    // Random stream: full rate for the first cycles, then random backpressure
    sent = 0;
    for (int c = 0; c < 2000 && (sent < 100 || q.size() > 0); c++) begin
      @(negedge clock);
      out_ready = (c < 30) ? 1'b1 : 1'($urandom_range(0, 1));
      if (sent < 100) begin
        in_valid = 1'b1;
        in_signed = 1'($urandom_range(0, 1));
        in_data = 8'($urandom_range(0, 255));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_ready) check("no_bubble_in_ready", in_ready, 1'b1);
      if (q.size() >= 2) check("full_pipe_valid", out_valid, 1'b1);
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("stream_spurious", 1'b1, 1'b0);
        else check("stream_result", dut_res(), q.pop_front());
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_model(in_signed, in_data));
        sent++;
      end
    end
    check("stream_drained", (q.size() == 0) && (sent == 100), 1'b1);
    q.delete();

    // Reset with two beats buffered
    @(negedge clock);
    out_ready = 1'b0; in_valid = 1'b1; in_signed = 1'b0; in_data = 8'h03;
    @(negedge clock);
    in_data = 8'h05;
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    check("buffered_valid", out_valid, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("midreset_out_valid", out_valid, 1'b0);
    check("midreset_outputs", dut_res(), 14'd0);
    check("midreset_in_ready", in_ready, 1'b0);
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    check("midreset_release_ready", in_ready, 1'b1);
    stale = 0;
    repeat (8) begin
      @(negedge clock);
      #1;
      if (out_valid) stale++;
    end
    check("no_stale_result", stale, 0);

`ifdef INT_TO_RAW_STATS_EN
    check("stat_conv_cleared", stat_conv, 32'd0);
    check("stat_zero_cleared", stat_zero, 32'd0);
    @(negedge clock);
    in_valid = 1'b1; in_signed = 1'b0; in_data = 8'h00;
    @(negedge clock);
    in_data = 8'h01;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    check("stat_conv_count", stat_conv, 32'd2);
    check("stat_zero_count", stat_zero, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
